// File: rtl/particle_rasterizer.sv
// particle_rasterizer
//   Snapshots four particle positions (12.4 fixed point) on a frame tick,
//   converts them to 16x16 cells, draws the outline triangle 0-1-2 with
//   Bresenham lines plus the centre particle into the back framebuffer,
//   then swaps buffers.
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   start          frame tick; accepted only when idle
//   x0..y3         signed positions; particle 3 is the centre
//   rd_row         front-buffer row address from the scan driver
//   rd_data        registered front-buffer row, bit c = column c
//   busy           high from start acceptance until the swap
//   done           one-cycle pulse in the cycle after the swap
//   frame_count    completed frames, wrapping
module particle_rasterizer #(
    parameter int GRID = 16,
    parameter int FRAC = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic signed [15:0] x0,
    input  logic signed [15:0] y0,
    input  logic signed [15:0] x1,
    input  logic signed [15:0] y1,
    input  logic signed [15:0] x2,
    input  logic signed [15:0] y2,
    input  logic signed [15:0] x3,
    input  logic signed [15:0] y3,
    input  logic [3:0]         rd_row,
    output logic [15:0]        rd_data,
    output logic               busy,
    output logic               done,
    output logic [7:0]         frame_count
);

    localparam int WIDTH = GRID << FRAC;

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_CLEAR, S_LINE_INIT, S_LINE_STEP, S_CENTER, S_SWAP
    } state_t;

    function automatic logic [3:0] to_cell(input logic signed [15:0] p);
        if (p < 0)
            return 4'd0;
        else if (32'(p) >= WIDTH)
            return 4'd15;
        else
            return p[FRAC+3:FRAC];
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         cx_q [4], cx_d [4];
    logic [3:0]         cy_q [4], cy_d [4];
    logic [3:0]         clr_q, clr_d;
    logic [1:0]         edge_q, edge_d;
    logic [3:0]         lx_q, lx_d, ly_q, ly_d;
    logic signed [7:0]  ldx_q, ldx_d, ldy_q, ldy_d, err_q, err_d;
    logic               sxn_q, sxn_d, syn_q, syn_d;   // step direction negative
    logic [15:0]        fb_q [2][16], fb_d [2][16];
    logic               front_q, front_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [7:0]         fc_q, fc_d;
    logic [15:0]        rd_q, rd_d;

    logic               back;
    logic [1:0]         ia, ib;
    logic [3:0]         xa, ya, xb, yb;
    logic [7:0]         adx, ady;
    logic signed [7:0]  e2, err_n;

    assign rd_data     = rd_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign frame_count = fc_q;

    always_comb begin
        back  = ~front_q;
        // Edge order (0,1), (1,2), (2,0): endpoint b wraps back to particle 0.
        ia    = edge_q;
        ib    = (edge_q == 2'd2) ? 2'd0 : edge_q + 2'd1;
        xa    = cx_q[ia];
        ya    = cy_q[ia];
        xb    = cx_q[ib];
        yb    = cy_q[ib];
        adx   = (xb >= xa) ? {4'b0, xb - xa} : {4'b0, xa - xb};
        ady   = (yb >= ya) ? {4'b0, yb - ya} : {4'b0, ya - yb};
        e2    = err_q <<< 1;
        err_n = err_q;

        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        clr_d   = clr_q;
        edge_d  = edge_q;
        lx_d    = lx_q;
        ly_d    = ly_q;
        ldx_d   = ldx_q;
        ldy_d   = ldy_q;
        err_d   = err_q;
        sxn_d   = sxn_q;
        syn_d   = syn_q;
        fb_d    = fb_q;
        front_d = front_q;
        busy_d  = busy_q;
        done_d  = (state_q == S_SWAP);
        fc_d    = fc_q;
        rd_d    = fb_q[front_q][rd_row];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LATCH;
                    busy_d  = 1'b1;
                end
            end
            S_LATCH: begin
                cx_d[0] = to_cell(x0);  cy_d[0] = to_cell(y0);
                cx_d[1] = to_cell(x1);  cy_d[1] = to_cell(y1);
                cx_d[2] = to_cell(x2);  cy_d[2] = to_cell(y2);
                cx_d[3] = to_cell(x3);  cy_d[3] = to_cell(y3);
                clr_d   = '0;
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                fb_d[back][clr_q] = '0;
                clr_d = clr_q + 4'd1;
                if (clr_q == 4'd15) begin
                    edge_d  = '0;
                    state_d = S_LINE_INIT;
                end
            end
            S_LINE_INIT: begin
                lx_d    = xa;
                ly_d    = ya;
                ldx_d   = $signed(adx);
                ldy_d   = -$signed(ady);
                err_d   = $signed(adx) - $signed(ady);
                sxn_d   = (xb < xa);
                syn_d   = (yb < ya);
                state_d = S_LINE_STEP;
            end
            S_LINE_STEP: begin
                fb_d[back][ly_q][lx_q] = 1'b1;
                if (lx_q == xb && ly_q == yb) begin
                    if (edge_q == 2'd2) begin
                        state_d = S_CENTER;
                    end else begin
                        edge_d  = edge_q + 2'd1;
                        state_d = S_LINE_INIT;
                    end
                end else begin
                    // Both tests use e2 from the start of the cycle, so a
                    // diagonal step applies both adjustments together.
                    if (e2 >= ldy_q) begin
                        err_n = err_n + ldy_q;
                        lx_d  = sxn_q ? lx_q - 4'd1 : lx_q + 4'd1;
                    end
                    if (e2 <= ldx_q) begin
                        err_n = err_n + ldx_q;
                        ly_d  = syn_q ? ly_q - 4'd1 : ly_q + 4'd1;
                    end
                    err_d = err_n;
                end
            end
            S_CENTER: begin
                fb_d[back][cy_q[3]][cx_q[3]] = 1'b1;
                state_d = S_SWAP;
            end
            S_SWAP: begin
                front_d = ~front_q;
                fc_d    = fc_q + 8'd1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            for (int unsigned i = 0; i < 4; i++) begin
                cx_q[i] <= '0;
                cy_q[i] <= '0;
            end
            for (int unsigned b = 0; b < 2; b++)
                for (int unsigned r = 0; r < 16; r++)
                    fb_q[b][r] <= '0;
            clr_q   <= '0;
            edge_q  <= '0;
            lx_q    <= '0;
            ly_q    <= '0;
            ldx_q   <= '0;
            ldy_q   <= '0;
            err_q   <= '0;
            sxn_q   <= 1'b0;
            syn_q   <= 1'b0;
            front_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fc_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            fb_q    <= fb_d;
            clr_q   <= clr_d;
            edge_q  <= edge_d;
            lx_q    <= lx_d;
            ly_q    <= ly_d;
            ldx_q   <= ldx_d;
            ldy_q   <= ldy_d;
            err_q   <= err_d;
            sxn_q   <= sxn_d;
            syn_q   <= syn_d;
            front_q <= front_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fc_q    <= fc_d;
            rd_q    <= rd_d;
        end
    end

endmodule

// File: tb/tb_particle_rasterizer.sv
// Directed testbench for particle_rasterizer with hand-computed images.
module tb_particle_rasterizer;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic signed [15:0] x0, y0, x1, y1, x2, y2, x3, y3;
    logic [3:0]         rd_row;
    logic [15:0]        rd_data;
    logic               busy, done;
    logic [7:0]         frame_count;

    int n_tests = 0;
    int n_fail  = 0;

    particle_rasterizer #(.GRID(16), .FRAC(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .x2(x2), .y2(y2), .x3(x3), .y3(y3),
        .rd_row(rd_row), .rd_data(rd_data),
        .busy(busy), .done(done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_pos(input int ax0, input int ay0, input int ax1, input int ay1,
                           input int ax2, input int ay2, input int ax3, input int ay3);
        x0 = 16'(ax0); y0 = 16'(ay0); x1 = 16'(ax1); y1 = 16'(ay1);
        x2 = 16'(ax2); y2 = 16'(ay2); x3 = 16'(ax3); y3 = 16'(ay3);
    endtask

    // Called #1 after a posedge; returns #1 after the edge that raised done.
    task automatic run_frame(output int lat);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        lat = -1;
        for (int cnt = 1; cnt <= 300; cnt++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = cnt;
                break;
            end
        end
        check("busy_low_at_done", busy, 0);
    endtask

    task automatic read_row(input int r, output logic [15:0] v);
        rd_row = 4'(r);
        @(posedge clk); #1;
        v = rd_data;
    endtask

    task automatic check_image(input string tag, input logic [15:0] img [16]);
        logic [15:0] v;
        for (int r = 0; r < 16; r++) begin
            read_row(r, v);
            check($sformatf("%s_row%0d", tag, r), v, img[r]);
        end
    endtask

    initial begin
        logic [15:0] img [16];
        int lat, ndone, old_err, exp_fc;
        logic prev_done;

        reset = 1'b1; start = 1'b0; rd_row = '0;
        set_pos(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_fc", frame_count, 0);
        for (int r = 0; r < 16; r++) img[r] = 16'h0000;
        check_image("reset", img);

        // All particles in cell 8
        set_pos(128, 128, 128, 128, 128, 128, 128, 128);
        run_frame(lat);
        check("single_cell_latency", lat, 25);
        check("single_cell_fc", frame_count, 1);
        for (int r = 0; r < 16; r++) img[r] = 16'h0000;
        img[8] = 16'h0100;
        check_image("single", img);

        // Reset in the middle of line drawing
        set_pos(0, 0, 240, 0, 0, 240, 128, 128);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (25) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_fc", frame_count, 0);
        check("midreset_rd", rd_data, 0);
        reset = 1'b0;
        for (int r = 0; r < 16; r++) img[r] = 16'h0000;
        check_image("midreset", img);

        // Triangle with centre
        run_frame(lat);
        check("triangle_latency", lat, 70);
        check("triangle_fc", frame_count, 1);
        for (int r = 0; r < 16; r++) begin
            img[r] = (r == 0) ? 16'hFFFF : (16'h0001 | (16'h0001 << (15 - r)));
        end
        img[8] = img[8] | 16'h0100;
        check_image("triangle", img);

        // Clamp, ignored second start, and read/swap timing on row 8
        set_pos(-5, 300, 16, 16, 16, 16, 16, 16);
        rd_row = 4'd8;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ndone = 0; old_err = 0; lat = -1; prev_done = 1'b0;
        for (int cnt = 1; cnt <= 120; cnt++) begin
            @(posedge clk); #1;
            if (cnt == 5) start = 1'b1;
            if (cnt == 6) start = 1'b0;
            if (prev_done) check("rd_new_after_swap", rd_data, 16'h0003);
            if (done) begin
                ndone++;
                if (ndone == 1) lat = cnt;
                check("rd_old_on_done", rd_data, 16'h0181);
            end else if (ndone == 0 && rd_data !== 16'h0181) begin
                old_err++;
            end
            prev_done = done;
        end
        check("clamp_done_count", ndone, 1);
        check("clamp_latency", lat, 53);
        check("clamp_old_frame_stable", old_err, 0);
        check("clamp_fc", frame_count, 2);
        img[0] = 16'h0000;
        for (int r = 1; r <= 7; r++) img[r] = 16'h0002;
        img[8] = 16'h0003;
        for (int r = 9; r <= 15; r++) img[r] = 16'h0001;
        check_image("clamp", img);

        // 256 back-to-back frames; each start lands in the done cycle
        set_pos(128, 128, 128, 128, 128, 128, 128, 128);
        exp_fc = 2;
        for (int i = 0; i < 256; i++) begin
            run_frame(lat);
            exp_fc = (exp_fc + 1) % 256;
            check($sformatf("loop_latency_%0d", i), lat, 25);
            check($sformatf("loop_fc_%0d", i), frame_count, exp_fc);
        end
        @(posedge clk); #1;
        check("loop_busy_idle", busy, 0);
        check("loop_done_cleared", done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
